// File: rtl/router_pkg.sv
// router_pkg: shared defaults for the sync/router block
package router_pkg;
  localparam int ROUTER_NUM_PORTS = 3;
  localparam int ROUTER_ADDR_W = 2;
  localparam int ROUTER_TIMEOUT = 30;
endpackage

// File: rtl/router_sync_timer.sv
// router_sync_timer: per-port idle-valid watchdog issuing a one-cycle soft_reset
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  logic inc;
  assign inc = vld & ~rd;
  // expire is the edge-aligned twin of soft_reset so the top can drop its destination on the same edge
  assign expire = inc && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= expire;
      cnt <= (inc && !expire) ? cnt + CW'(1) : '0;
    end
endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: latches packet destination, steers FIFO writes, and times out unread ports
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int ADDR_W = ROUTER_ADDR_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);
  logic [ADDR_W-1:0] dest_q;
  logic dest_vld;
  logic in_range;
  logic [NUM_PORTS-1:0] expire;
  assign in_range = int'(data_in) < NUM_PORTS;
  assign vld_out = ~empty;
  assign write_enb = (write_enb_reg && dest_vld) ? NUM_PORTS'(1) << dest_q : '0;
  assign fifo_full = dest_vld ? full[dest_q] : 1'b0;
  // a new header outranks a timeout on the current destination
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      dest_q <= '0;
      dest_vld <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= detect_add && !in_range;
      if (detect_add) begin
        dest_q <= data_in;
        dest_vld <= in_range;
      end else if (dest_vld && expire[dest_q]) begin
        dest_vld <= 1'b0;
      end
    end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock(clock),
      .resetn(resetn),
      .vld(vld_out[g]),
      .rd(read_enb[g]),
      .soft_reset(soft_reset[g]),
      .expire(expire[g])
    );
  end
endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: directed and randomized checks against a cycle-level reference model
module tb_router_sync_n;
  localparam int NP = 3;
  localparam int AW = 2;
  localparam int TO = 30;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic detect_add = 1'b0;
  logic write_enb_reg = 1'b0;
  logic [AW-1:0] data_in = '0;
  logic [NP-1:0] full = '0;
  logic [NP-1:0] empty = '1;
  logic [NP-1:0] read_enb = '0;
  logic [NP-1:0] write_enb, vld_out, soft_reset;
  logic fifo_full, addr_err;
  int n_chk = 0;
  int n_fail = 0;
  int m_dest;
  bit m_dvld, m_aerr;
  int streak[NP];
  bit m_sr[NP];

  router_sync_n #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock),
    .resetn(resetn),
    .detect_add(detect_add),
    .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .full(full),
    .empty(empty),
    .read_enb(read_enb),
    .write_enb(write_enb),
    .fifo_full(fifo_full),
    .vld_out(vld_out),
    .soft_reset(soft_reset),
    .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_dest = 0;
    m_dvld = 0;
    m_aerr = 0;
    for (int i = 0; i < NP; i++) begin
      streak[i] = 0;
      m_sr[i] = 0;
    end
  endfunction

  task automatic step(input bit da, input int di, input bit wr, input logic [NP-1:0] f,
                      input logic [NP-1:0] e, input logic [NP-1:0] r);
    logic [NP-1:0] ve;
    logic [NP-1:0] we;
    @(negedge clock);
    detect_add = da;
    data_in = AW'(di);
    write_enb_reg = wr;
    full = f;
    empty = e;
    read_enb = r;
    #1;
    ve = ~e;
    we = (wr && m_dvld) ? NP'(1 << m_dest) : '0;
    check("write_enb", write_enb, we);
    check("fifo_full", fifo_full, m_dvld ? f[m_dest] : 1'b0);
    check("vld_out", vld_out, ve);
    check("addr_err", addr_err, m_aerr);
    for (int i = 0; i < NP; i++) check("soft_reset", soft_reset[i], m_sr[i]);
    for (int i = 0; i < NP; i++) begin
      if (!e[i] && !r[i]) begin
        streak[i]++;
        m_sr[i] = (streak[i] == TO);
        if (m_sr[i]) streak[i] = 0;
      end else begin
        streak[i] = 0;
        m_sr[i] = 0;
      end
    end
    m_aerr = da && di >= NP;
    if (da) begin
      m_dest = di;
      m_dvld = di < NP;
    end else if (m_dvld && m_sr[m_dest]) begin
      m_dvld = 0;
    end
  endtask

  initial begin
    int ep[NP];
    model_reset();
    write_enb_reg = 1'b1;
    full = '1;
    #1;
    check("rst_write_enb", write_enb, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_soft_reset", soft_reset, 0);
    check("rst_addr_err", addr_err, 0);
    @(negedge clock);
    resetn = 1'b1;
    step(1, 1, 0, '0, '1, '0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 3'b010, '1, '0);
      check("hdr1_write_enb", write_enb, 3'b010);
      check("hdr1_fifo_full", fifo_full, 1);
    end
    step(0, 0, 1, 3'b101, '1, '0);
    check("hdr1_fifo_clear", fifo_full, 0);
    step(1, 3, 0, '0, '1, '0);
    step(0, 0, 1, '0, '1, '0);
    check("bad_addr_err", addr_err, 1);
    check("bad_write_enb", write_enb, 0);
    step(0, 0, 1, '0, '1, '0);
    check("bad_addr_err_end", addr_err, 0);
    for (int k = 1; k <= 32; k++) begin
      step(0, 0, 0, '0, 3'b110, '0);
      check("timeout_pulse", soft_reset[0], k == 31);
    end
    step(0, 0, 0, '0, '1, '0);
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, '0, 3'b110, (k == 29) ? 3'b001 : 3'b000);
      check("read_suppress", soft_reset[0], 0);
    end
    step(0, 0, 0, '0, '1, '0);
    step(1, 2, 1, '0, 3'b011, '0);
    for (int k = 2; k <= 32; k++) begin
      step(0, 0, 1, '0, 3'b011, '0);
      check("stream_write_enb", write_enb, (k <= 30) ? 3'b100 : 3'b000);
      check("stream_pulse", soft_reset[2], k == 31);
    end
    step(0, 0, 0, '0, '1, '0);
    step(1, 2, 1, '0, 3'b011, '0);
    for (int k = 2; k <= 32; k++) begin
      step(k == 30, 2, 1, '0, 3'b011, '0);
      check("hdr_wins_write_enb", write_enb, 3'b100);
      check("hdr_wins_pulse", soft_reset[2], k == 31);
    end
    step(1, 1, 1, '0, '1, '0);
    step(0, 0, 1, '1, '1, '0);
    check("pre_rst_write_enb", write_enb, 3'b010);
    #2;
    resetn = 1'b0;
    #1;
    check("async_write_enb", write_enb, 0);
    check("async_fifo_full", fifo_full, 0);
    check("async_soft_reset", soft_reset, 0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    step(0, 0, 1, '1, '1, '0);
    check("post_rst_write_enb", write_enb, 0);
    step(1, 0, 1, '1, '1, '0);
    step(0, 0, 1, '1, '1, '0);
    check("post_rst_new_hdr", write_enb, 3'b001);
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < NP; i++) ep[i] = (p % 3 == 0) ? 8 : int'($urandom_range(0, 1));
      for (int k = 0; k < 40; k++) begin
        logic [NP-1:0] e, r;
        for (int i = 0; i < NP; i++) begin
          e[i] = ($urandom % 64) < ep[i];
          r[i] = ($urandom % 48) == 0;
        end
        step(($urandom % 6) == 0, int'($urandom % 4), $urandom % 2 == 1, NP'($urandom), e, r);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, meaning number of output FIFOs/channels (2..16).
REQ-002 SHALL have parameter ADDR_W, default 2, meaning destination address width, >= clog2(NUM_PORTS).
REQ-003 SHALL have parameter TIMEOUT, default 30, meaning cycles a port may sit valid-unread before soft reset (2..1023).
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port detect_add  input  1  header cycle; data_in carries destination.
REQ-007 SHALL have port data_in  input  ADDR_W  destination address.
REQ-008 SHALL have port write_enb_reg  input  1  FSM request to write current byte.
REQ-009 SHALL have port full  input  NUM_PORTS  per-FIFO full.
REQ-010 SHALL have port empty  input  NUM_PORTS  per-FIFO empty.
REQ-011 SHALL have port read_enb  input  NUM_PORTS  per-FIFO read strobe.
REQ-012 SHALL have port write_enb  output  NUM_PORTS  one-hot FIFO write enable.
REQ-013 SHALL have port fifo_full  output  1  full flag of latched destination.
REQ-014 SHALL have port vld_out  output  NUM_PORTS  per-port valid.
REQ-015 SHALL have port soft_reset  output  NUM_PORTS  per-port timeout reset pulse.
REQ-016 SHALL have port addr_err  output  1  one-cycle pulse on out-of-range address.

Function
REQ-017 On detect_add=1, dest_q SHALL load data_in next edge; dest_vld SHALL be 1 if data_in < NUM_PORTS, else 0 with addr_err=1 for that one cycle.
REQ-018 dest_q/dest_vld SHALL hold until next detect_add (no per-cycle release).
REQ-019 write_enb SHALL be combinational: bit dest_q set only when write_enb_reg=1 and dest_vld=1; else all zero; never more than one bit.
REQ-020 fifo_full SHALL be combinational full[dest_q] when dest_vld=1, else 0.
REQ-021 vld_out[i] SHALL equal ~empty[i] combinationally.
REQ-022 Per port, counter SHALL increment when vld_out[i]=1 and read_enb[i]=0; clear when read_enb[i]=1 or vld_out[i]=0.
REQ-023 When counter = TIMEOUT-1 and increment condition holds, soft_reset[i] SHALL be 1 on the next cycle only, and counter SHALL clear; soft_reset registered.
REQ-024 Counter width SHALL be clog2(TIMEOUT); counter SHALL never exceed TIMEOUT-1 (no wrap).
REQ-025 soft_reset[i] asserting while dest_q=i SHALL clear dest_vld same edge; simultaneous detect_add SHALL win (new address loaded).
REQ-026 Ports SHALL time out independently; simultaneous soft_reset on several ports SHALL be allowed.
REQ-027 read_enb[i] asserted at counter TIMEOUT-1 SHALL suppress the pulse and clear counter.

Reset
REQ-028 resetn=0 SHALL asynchronously clear dest_q, dest_vld, addr_err, all counters and soft_reset; write_enb and fifo_full SHALL thus be 0.
REQ-029 Reset mid-packet SHALL abandon destination; writes SHALL resume only after a new detect_add.

Structure
REQ-030 Package router_pkg SHALL hold ROUTER_NUM_PORTS, ROUTER_ADDR_W and ROUTER_TIMEOUT defaults.
REQ-031 Per-port timer SHALL be sub-module router_sync_timer (vld, rd, soft_reset), instantiated NUM_PORTS times by generate loop.

Verification
REQ-032 detect_add, data_in=1, then write_enb_reg=1 for 3 cycles -> write_enb=3'b010 each cycle; fifo_full follows full[1].
REQ-033 detect_add, data_in=3 (NUM_PORTS=3) -> addr_err pulses 1 cycle; write_enb=0 despite write_enb_reg=1.
REQ-034 empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0]=1 exactly on cycle 31, one cycle wide; counter restarts.
REQ-035 Same as above but read_enb[0]=1 at cycle 29 -> no soft_reset; counter cleared.
REQ-036 dest_q=2 streaming, port 2 times out -> write_enb=0 after pulse; detect_add same cycle as pulse -> new destination used.
REQ-037 resetn=0 mid-packet between edges -> outputs 0 immediately; no write until new detect_add.
